// File: rtl/lsu_mem_master_pkg.sv
// Shared funct3 size-select codes, LSU state encoding and small decode helpers
// used by the LSU initiator and its lane aligner.
package lsu_mem_master_pkg;

    localparam logic [2:0] SEL_BYTE = 3'b000;
    localparam logic [2:0] SEL_HALF = 3'b001;
    localparam logic [2:0] SEL_WORD = 3'b010;
    localparam logic [2:0] SEL_DWRD = 3'b011;
    localparam logic [2:0] SEL_BYTU = 3'b100;
    localparam logic [2:0] SEL_HLFU = 3'b101;
    localparam logic [2:0] SEL_WRDU = 3'b110;
    localparam logic [2:0] SEL_ILL  = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_B0   = 3'd1,
        ST_W0   = 3'd2,
        ST_B1   = 3'd3,
        ST_W1   = 3'd4,
        ST_RESP = 3'd5
    } lsu_state_e;

    // Access size in bytes; bit 2 of funct3 only selects zero-extension.
    function automatic logic [3:0] sel_size(input logic [2:0] funct3);
        logic [3:0] size;
        case (funct3[1:0])
            2'b00:   size = 4'd1;
            2'b01:   size = 4'd2;
            2'b10:   size = 4'd4;
            default: size = 4'd8;
        endcase
        return size;
    endfunction

    // Unsigned selects have no meaning for stores; 3'b111 is undefined for both.
    function automatic logic sel_illegal(input logic we, input logic [2:0] funct3);
        return (funct3 == SEL_ILL) || (we && funct3[2]);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane alignment: store byte enables and data shifted into
// one or two doubleword beats, and load merge of two beats with extension.
module lsu_lane_align
    import lsu_mem_master_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [2:0]  off_i,
    input  logic [63:0] wdata_i,
    input  logic [63:0] beat0_i,
    input  logic [63:0] beat1_i,
    output logic        split_o,
    output logic [7:0]  be0_o,
    output logic [7:0]  be1_o,
    output logic [63:0] wdata0_o,
    output logic [63:0] wdata1_o,
    output logic [63:0] ldata_o
);

    logic [3:0]   size;
    logic [15:0]  mask;
    logic [15:0]  mask_sh;
    logic [127:0] wide_w;
    logic [63:0]  raw_unused_hi;
    logic [63:0]  raw;
    logic         sgn;

    always_comb begin
        size     = sel_size(funct3_i);
        split_o  = ({1'b0, off_i} + size) > 4'd8;
        mask     = (16'd1 << size) - 16'd1;
        mask_sh  = mask << off_i;
        be0_o    = mask_sh[7:0];
        be1_o    = mask_sh[15:8];

        // Upper half of the 128-bit shift is exactly the spill into the next doubleword.
        wide_w   = {64'd0, wdata_i} << {off_i, 3'b000};
        wdata0_o = wide_w[63:0];
        wdata1_o = wide_w[127:64];

        {raw_unused_hi, raw} = {beat1_i, beat0_i} >> {off_i, 3'b000};
        sgn      = !funct3_i[2];
        case (size)
            4'd1:    ldata_o = {{56{sgn & raw[7]}},  raw[7:0]};
            4'd2:    ldata_o = {{48{sgn & raw[15]}}, raw[15:0]};
            4'd4:    ldata_o = {{32{sgn & raw[31]}}, raw[31:0]};
            default: ldata_o = raw;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator: converts byte-addressed requests into one or two
// doubleword memory beats and returns sign/zero-extended load data.
//  state | meaning
//  IDLE  | ready, waiting for a request
//  B0    | first beat requested, waiting for grant
//  W0    | waiting for first read beat data
//  B1    | second beat (next doubleword) requested
//  W1    | waiting for second read beat data
//  RESP  | one-cycle response pulse
module lsu_mem_master
    import lsu_mem_master_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int IDX_W  = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [63:0]       wdata_i,
    output logic              resp_valid_o,
    output logic              resp_err_o,
    output logic [63:0]       rdata_o,
    output logic              mem_req_o,
    input  logic              mem_gnt_i,
    output logic              mem_wen_n_o,
    output logic [IDX_W-1:0]  mem_addr_o,
    output logic [7:0]        mem_be_o,
    output logic [63:0]       mem_wdata_o,
    input  logic              mem_rvalid_i,
    input  logic [63:0]       mem_rdata_i
);

    lsu_state_e       state_q;
    logic             we_q;
    logic [2:0]       funct3_q;
    logic [2:0]       off_q;
    logic [IDX_W-1:0] idx_q;
    logic [63:0]      wdata_q;
    logic [63:0]      beat0_q;
    logic [63:0]      rdata_q;
    logic             resp_valid_q;
    logic             resp_err_q;

    logic             split;
    logic [7:0]       be0;
    logic [7:0]       be1;
    logic [63:0]      wd0;
    logic [63:0]      wd1;
    logic [63:0]      ldata;
    logic [63:0]      merge_beat0;
    logic             in_beat;
    logic             second;
    logic             unused_addr;

    assign unused_addr = ^addr_i[ADDR_W-1:IDX_W+3];

    // In W0 the first beat is live on the bus; in W1 it comes from the capture register.
    assign merge_beat0 = (state_q == ST_W1) ? beat0_q : mem_rdata_i;

    lsu_lane_align u_align (
        .funct3_i (funct3_q),
        .off_i    (off_q),
        .wdata_i  (wdata_q),
        .beat0_i  (merge_beat0),
        .beat1_i  (mem_rdata_i),
        .split_o  (split),
        .be0_o    (be0),
        .be1_o    (be1),
        .wdata0_o (wd0),
        .wdata1_o (wd1),
        .ldata_o  (ldata)
    );

    // Beat outputs depend only on registered state, so they cannot move while stalled.
    assign in_beat      = (state_q == ST_B0) || (state_q == ST_B1);
    assign second       = (state_q == ST_B1);
    assign req_ready_o  = (state_q == ST_IDLE);
    assign resp_valid_o = resp_valid_q;
    assign resp_err_o   = resp_err_q;
    assign rdata_o      = rdata_q;
    assign mem_req_o    = in_beat;
    assign mem_wen_n_o  = !(in_beat && we_q);
    assign mem_addr_o   = !in_beat ? '0 : (second ? idx_q + IDX_W'(1) : idx_q);
    assign mem_be_o     = !in_beat ? 8'd0 : (second ? be1 : be0);
    assign mem_wdata_o  = !(in_beat && we_q) ? 64'd0 : (second ? wd1 : wd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            funct3_q     <= 3'd0;
            off_q        <= 3'd0;
            idx_q        <= '0;
            wdata_q      <= 64'd0;
            beat0_q      <= 64'd0;
            rdata_q      <= 64'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        we_q     <= req_we_i;
                        funct3_q <= funct3_i;
                        off_q    <= addr_i[2:0];
                        idx_q    <= addr_i[IDX_W+2:3];
                        wdata_q  <= wdata_i;
                        if (sel_illegal(req_we_i, funct3_i)) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            rdata_q      <= 64'd0;
                        end else begin
                            state_q <= ST_B0;
                        end
                    end
                end
                ST_B0: begin
                    if (mem_gnt_i) begin
                        if (!we_q) begin
                            state_q <= ST_W0;
                        end else if (split) begin
                            state_q <= ST_B1;
                        end else begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            rdata_q      <= 64'd0;
                        end
                    end
                end
                ST_W0: begin
                    if (mem_rvalid_i) begin
                        beat0_q <= mem_rdata_i;
                        if (split) begin
                            state_q <= ST_B1;
                        end else begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            rdata_q      <= ldata;
                        end
                    end
                end
                ST_B1: begin
                    if (mem_gnt_i) begin
                        if (we_q) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            rdata_q      <= 64'd0;
                        end else begin
                            state_q <= ST_W1;
                        end
                    end
                end
                ST_W1: begin
                    if (mem_rvalid_i) begin
                        state_q      <= ST_RESP;
                        resp_valid_q <= 1'b1;
                        rdata_q      <= ldata;
                    end
                end
                ST_RESP: begin
                    state_q      <= ST_IDLE;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: directed cases then randomized loads/stores checked
// against a byte-array memory model, with a stalling memory responder.
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [2:0]  funct3_i = 3'd0;
    logic [63:0] addr_i = 64'd0;
    logic [63:0] wdata_i = 64'd0;
    logic        resp_valid_o;
    logic        resp_err_o;
    logic [63:0] rdata_o;
    logic        mem_req_o;
    logic        mem_gnt_i = 1'b1;
    logic        mem_wen_n_o;
    logic [11:0] mem_addr_o;
    logic [7:0]  mem_be_o;
    logic [63:0] mem_wdata_o;
    logic        mem_rvalid_i = 1'b0;
    logic [63:0] mem_rdata_i = 64'd0;

    lsu_mem_master #(.ADDR_W(64), .IDX_W(12)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .funct3_i     (funct3_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .resp_valid_o (resp_valid_o),
        .resp_err_o   (resp_err_o),
        .rdata_o      (rdata_o),
        .mem_req_o    (mem_req_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_wen_n_o  (mem_wen_n_o),
        .mem_addr_o   (mem_addr_o),
        .mem_be_o     (mem_be_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wen_n;
        logic [11:0] addr;
        logic [7:0]  be;
        logic [63:0] wdata;
    } beat_t;

    int          checks = 0;
    int          failures = 0;
    beat_t       beats[$];
    logic [63:0] dmem [4096];
    logic [7:0]  ref_mem [32768];
    int          stall_cnt = 0;
    bit          rand_gnt = 1'b0;
    logic        prev_req = 1'b0;
    logic        prev_gnt = 1'b0;
    logic        prev_wen;
    logic [11:0] prev_addr;
    logic [7:0]  prev_be;
    logic [63:0] prev_wdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory: accepts beats on grant, returns read data exactly one cycle later.
    always @(posedge clk) begin
        mem_rvalid_i <= 1'b0;
        if (rst_n && mem_req_o && mem_gnt_i) begin
            beats.push_back('{mem_wen_n_o, mem_addr_o, mem_be_o, mem_wdata_o});
            if (!mem_wen_n_o) begin
                for (int b = 0; b < 8; b++)
                    if (mem_be_o[b]) dmem[mem_addr_o][8*b +: 8] = mem_wdata_o[8*b +: 8];
            end else begin
                mem_rvalid_i <= 1'b1;
                mem_rdata_i  <= dmem[mem_addr_o];
            end
        end
    end

    // Stall-stability monitor and grant generator.
    always @(negedge clk) begin
        if (rst_n && prev_req && !prev_gnt) begin
            chk("hold_req",   64'(mem_req_o),   64'd1);
            chk("hold_wen",   64'(mem_wen_n_o), 64'(prev_wen));
            chk("hold_addr",  64'(mem_addr_o),  64'(prev_addr));
            chk("hold_be",    64'(mem_be_o),    64'(prev_be));
            chk("hold_wdata", mem_wdata_o,      prev_wdata);
        end
        if (mem_req_o && stall_cnt > 0) begin
            mem_gnt_i = 1'b0;
            stall_cnt--;
        end else begin
            mem_gnt_i = rand_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        prev_req   = rst_n && mem_req_o;
        prev_gnt   = mem_gnt_i;
        prev_wen   = mem_wen_n_o;
        prev_addr  = mem_addr_o;
        prev_be    = mem_be_o;
        prev_wdata = mem_wdata_o;
    end

    task automatic op(input logic we, input logic [2:0] f3, input logic [63:0] a,
                      input logic [63:0] wd, input bit chk_lat, input int extra,
                      output logic [63:0] rd);
        int          sz, off, lat, n, pos, exp_lat, nbeats;
        bit          ill, split;
        logic [7:0]  be0, be1, ebe;
        logic [127:0] lanes;
        logic [63:0] exp_rd, bmask, elane;
        logic [11:0] idx;
        ill   = (f3 == 3'b111) || (we && f3[2]);
        sz    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 8;
        off   = int'(a[2:0]);
        split = (off + sz) > 8;
        idx   = a[14:3];
        be0   = 8'd0;
        be1   = 8'd0;
        lanes = 128'd0;
        for (int i = 0; i < sz; i++) begin
            pos = off + i;
            if (pos < 8) be0[pos] = 1'b1;
            else         be1[pos-8] = 1'b1;
            lanes[8*pos +: 8] = wd[8*i +: 8];
        end
        exp_rd = 64'd0;
        if (!ill && !we) begin
            for (int i = 0; i < sz; i++) exp_rd[8*i +: 8] = ref_mem[(int'(a[14:0]) + i) % 32768];
            if (!f3[2] && sz < 8 && exp_rd[8*sz-1])
                for (int i = 8*sz; i < 64; i++) exp_rd[i] = 1'b1;
        end
        if (!ill && we)
            for (int i = 0; i < sz; i++) ref_mem[(int'(a[14:0]) + i) % 32768] = wd[8*i +: 8];
        exp_lat = ill ? 1 : (we ? (split ? 3 : 2) : (split ? 5 : 3));
        exp_lat += extra;
        nbeats  = ill ? 0 : (split ? 2 : 1);

        @(negedge clk);
        beats.delete();
        req_valid_i = 1'b1;
        req_we_i    = we;
        funct3_i    = f3;
        addr_i      = a;
        wdata_i     = wd;
        n = 0;
        while (!req_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", 64'(req_ready_o), 64'd1);
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        lat = 1;
        while (!resp_valid_o && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("resp_seen", 64'(resp_valid_o), 64'd1);
        chk("resp_err",  64'(resp_err_o),   64'(ill));
        chk("rdata",     rdata_o,           exp_rd);
        rd = rdata_o;
        if (chk_lat) chk("latency", 64'(lat), 64'(exp_lat));
        @(posedge clk);
        #1;
        chk("resp_pulse", 64'(resp_valid_o), 64'd0);
        chk("beat_count", 64'(beats.size()), 64'(nbeats));
        for (int k = 0; k < beats.size() && k < 2; k++) begin
            ebe = (k == 0) ? be0 : be1;
            chk("beat_addr", 64'(beats[k].addr),  64'(12'(idx + 12'(k))));
            chk("beat_be",   64'(beats[k].be),    64'(ebe));
            chk("beat_wen",  64'(beats[k].wen_n), 64'(!we));
            if (we) begin
                bmask = 64'd0;
                for (int b = 0; b < 8; b++) if (ebe[b]) bmask[8*b +: 8] = 8'hFF;
                elane = (k == 0) ? lanes[63:0] : lanes[127:64];
                chk("beat_wdata", beats[k].wdata & bmask, elane & bmask);
            end
        end
    endtask

    initial begin
        logic [63:0] rd;
        logic [63:0] ra;
        int          seen, errs;
        for (int i = 0; i < 4096; i++) begin
            dmem[i] = {$urandom, $urandom};
            for (int b = 0; b < 8; b++) ref_mem[8*i+b] = dmem[i][8*b +: 8];
        end

        #1 rst_n = 1'b0;
        #2;
        chk("rst_ready",  64'(req_ready_o),  64'd1);
        chk("rst_rvalid", 64'(resp_valid_o), 64'd0);
        chk("rst_req",    64'(mem_req_o),    64'd0);
        chk("rst_wen",    64'(mem_wen_n_o),  64'd1);
        chk("rst_rdata",  rdata_o,           64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        op(1'b1, 3'b011, 64'h10, 64'h1122334455667788, 1'b1, 0, rd);
        op(1'b0, 3'b011, 64'h10, 64'h0, 1'b1, 0, rd);
        chk("ld_dword", rd, 64'h1122334455667788);

        op(1'b1, 3'b000, 64'h13, 64'h80, 1'b1, 0, rd);
        op(1'b0, 3'b000, 64'h13, 64'h0, 1'b1, 0, rd);
        chk("lb_signed", rd, 64'hFFFFFFFFFFFFFF80);
        op(1'b0, 3'b100, 64'h13, 64'h0, 1'b1, 0, rd);
        chk("lbu", rd, 64'h80);

        op(1'b1, 3'b010, 64'h0E, 64'hDEADBEEF, 1'b1, 0, rd);
        op(1'b0, 3'b110, 64'h0E, 64'h0, 1'b1, 0, rd);
        chk("lwu_split", rd, 64'hDEADBEEF);
        op(1'b0, 3'b010, 64'h0E, 64'h0, 1'b1, 0, rd);
        chk("lw_split", rd, 64'hFFFFFFFFDEADBEEF);

        stall_cnt = 3;
        op(1'b1, 3'b011, 64'h20, 64'hCAFEF00D12345678, 1'b1, 3, rd);
        stall_cnt = 3;
        op(1'b0, 3'b001, 64'h7FFF, 64'h0, 1'b1, 3, rd);

        op(1'b0, 3'b111, 64'h40, 64'h0, 1'b1, 0, rd);
        op(1'b1, 3'b101, 64'h40, 64'h1234, 1'b1, 0, rd);

        // Reset while the first read beat of a split load is outstanding.
        @(negedge clk);
        req_valid_i = 1'b1;
        req_we_i    = 1'b0;
        funct3_i    = 3'b010;
        addr_i      = 64'h0E;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready",  64'(req_ready_o),  64'd1);
        chk("mid_rst_rvalid", 64'(resp_valid_o), 64'd0);
        chk("mid_rst_err",    64'(resp_err_o),   64'd0);
        chk("mid_rst_rdata",  rdata_o,           64'd0);
        chk("mid_rst_req",    64'(mem_req_o),    64'd0);
        chk("mid_rst_wen",    64'(mem_wen_n_o),  64'd1);
        chk("mid_rst_addr",   64'(mem_addr_o),   64'd0);
        chk("mid_rst_be",     64'(mem_be_o),     64'd0);
        chk("mid_rst_wdata",  mem_wdata_o,       64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (resp_valid_o) seen++;
        end
        chk("mid_rst_no_resp", 64'(seen), 64'd0);
        chk("mid_rst_ready_after", 64'(req_ready_o), 64'd1);

        rand_gnt = 1'b1;
        for (int t = 0; t < 250; t++) begin
            ra = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) ra[14:0] = 15'(32760 + $urandom_range(0, 7));
            else                          ra[14:0] = 15'($urandom_range(0, 255));
            op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra,
               {$urandom, $urandom}, 1'b0, 0, rd);
        end
        rand_gnt = 1'b0;

        errs = 0;
        for (int i = 0; i < 4096; i++)
            for (int b = 0; b < 8; b++)
                if (dmem[i][8*b +: 8] !== ref_mem[8*i+b]) errs++;
        chk("mem_image", 64'(errs), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
